freq_meter: RTL

//  Gated frequency counter clocked from the 100 MHz crystal. Counts rising edges of an

---
 rtl/freq_meter.sv | 101 ++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES XTAL_OSC cycles, in one-shot or continuous mode.
module freq_meter #(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int CNT_W       = 28,
  parameter int SYNC_STAGES = 2
) (
  input  logic             XTAL_OSC,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             hist;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_next;
  logic             ovf_int, ovf_next;
  logic             last_cycle;

  always_ff @(posedge XTAL_OSC or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det   = sync_q[SYNC_STAGES-1] & ~hist;
  assign last_cycle = (state == MEASURE) && (gate_cnt == GATE_LAST);
  assign busy       = (state == MEASURE);

  always_ff @(posedge XTAL_OSC or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start || continuous) state_next = MEASURE;
      MEASURE: if (last_cycle && !continuous) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Count including the current cycle's edge, so the final window cycle is reported.
  always_comb begin
    edge_cnt_next = edge_cnt;
    ovf_next      = ovf_int;
    if (edge_det) begin
      if (edge_cnt == CNT_MAX) ovf_next = 1'b1;
      else                     edge_cnt_next = edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge XTAL_OSC or negedge rst) begin
    if (!rst) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_int    <= 1'b0;
      freq       <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (state == IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf_int  <= 1'b0;
      end else if (last_cycle) begin
        freq       <= edge_cnt_next;
        overflow   <= ovf_next;
        freq_valid <= 1'b1;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        ovf_int    <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= edge_cnt_next;
        ovf_int  <= ovf_next;
      end
    end
  end

endmodule
